memory_stage: RTL and testbench

Y86-style processor memory stage: decodes the instruction code, selects the data-memory address and write data, and performs the access. It holds a word-addressed data RAM and returns the loaded value `valM` together with a data-memory error flag. It sits between execute (`valE`) and write-back, and feeds `dmem_error` to the status logic.

---
 rtl/memory_stage_pkg.sv | 17 +
 rtl/memory_stage_if.sv | 24 ++
 rtl/memory_stage_dmem_array.sv | 23 ++
 rtl/memory_stage.sv | 44 ++++
 tb/tb_memory_stage.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared widths, Y86 icode constants and status codes
package memory_stage_pkg;
  localparam int DATA_WID_DEF = 32;
  localparam int ICODE_WID_DEF = 4;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET = 4'h9;
  localparam logic [3:0] I_PUSHL = 4'hA;
  localparam logic [3:0] I_POPL = 4'hB;
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-side operands in, memory-stage results out
interface memory_stage_if import memory_stage_pkg::*; #(
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int ICODE_WID = ICODE_WID_DEF
);
  logic [ICODE_WID-1:0] icode;
  logic [DATA_WID-1:0] valE;
  logic [DATA_WID-1:0] valA;
  logic [DATA_WID-1:0] valP;
  logic [DATA_WID-1:0] valM;
  logic [DATA_WID-1:0] mem_addr;
  logic [DATA_WID-1:0] mem_wdata;
  logic dmem_error;
  logic mem_read;
  logic mem_write;
  modport master (
    output icode, valE, valA, valP,
    input valM, dmem_error, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport slave (
    input icode, valE, valA, valP,
    output valM, dmem_error, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/memory_stage_dmem_array.sv
// dmem_array: word RAM with async-reset clear, one write port and one combinational read port
module dmem_array #(
  parameter int DATA_WID = 32,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic rst_n,
  input logic we,
  input logic [$clog2(DEPTH)-1:0] waddr,
  input logic [DATA_WID-1:0] wdata,
  input logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WID-1:0] rdata
);
  logic [DATA_WID-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86 memory stage decoding icode, selecting address/write data and accessing data RAM
module memory_stage import memory_stage_pkg::*; #(
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int ICODE_WID = ICODE_WID_DEF,
  parameter int MEM_DEPTH = 256
) (
  input logic clk,
  input logic rst_n,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [ICODE_WID-1:0] C_RM = ICODE_WID'(I_RMMOVL);
  localparam logic [ICODE_WID-1:0] C_MR = ICODE_WID'(I_MRMOVL);
  localparam logic [ICODE_WID-1:0] C_CALL = ICODE_WID'(I_CALL);
  localparam logic [ICODE_WID-1:0] C_RET = ICODE_WID'(I_RET);
  localparam logic [ICODE_WID-1:0] C_PUSH = ICODE_WID'(I_PUSHL);
  localparam logic [ICODE_WID-1:0] C_POP = ICODE_WID'(I_POPL);
  logic rd, wr, err;
  logic [DATA_WID-1:0] addr, wdata, rdata;
  always_comb begin
    rd = bus.icode == C_MR || bus.icode == C_RET || bus.icode == C_POP;
    wr = bus.icode == C_RM || bus.icode == C_CALL || bus.icode == C_PUSH;
    addr = (bus.icode == C_RM || bus.icode == C_MR || bus.icode == C_CALL || bus.icode == C_PUSH) ? bus.valE
         : (bus.icode == C_RET || bus.icode == C_POP) ? bus.valA : '0;
    wdata = (bus.icode == C_RM || bus.icode == C_PUSH) ? bus.valA : bus.icode == C_CALL ? bus.valP : '0;
    // full-width unsigned range check: any bit above the index field is out of range
    err = (rd | wr) && addr[DATA_WID-1:AW] != '0;
  end
  dmem_array #(.DATA_WID(DATA_WID), .DEPTH(MEM_DEPTH)) u_dmem (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr && !err),
    .waddr(addr[AW-1:0]),
    .wdata(wdata),
    .raddr(addr[AW-1:0]),
    .rdata(rdata)
  );
  assign bus.mem_read = rd;
  assign bus.mem_write = wr;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
  assign bus.dmem_error = err;
  assign bus.valM = (rd && !err) ? rdata : '0;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of decode, select, range, access and reset behaviour
module tb_memory_stage;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  memory_stage_if #(.DATA_WID(32), .ICODE_WID(4)) bus ();
  memory_stage #(.DATA_WID(32), .ICODE_WID(4), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] ic, input logic [31:0] e, input logic [31:0] a, input logic [31:0] p);
    bus.icode = ic;
    bus.valE = e;
    bus.valA = a;
    bus.valP = p;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'h5, 32'd3, 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'h0) begin fails++; $display("FAIL reset_valM: got %h want 0", bus.valM); end
    checks++; if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL reset_read: got %b want 1", bus.mem_read); end
    checks++; if (bus.dmem_error !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.dmem_error); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_fill();
    for (int k = 0; k < 8; k++) begin
      drive(4'h4, 32'(k), 32'(k * 'h11), 32'h0);
      checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.dmem_error !== 1'b0) begin
        fails++; $display("FAIL fill_decode k=%0d: w=%b r=%b err=%b want 1 0 0", k, bus.mem_write, bus.mem_read, bus.dmem_error);
      end
      checks++; if (bus.mem_wdata !== 32'(k * 'h11)) begin fails++; $display("FAIL fill_wdata k=%0d: got %h want %h", k, bus.mem_wdata, k * 'h11); end
      next_cycle();
      drive(4'h5, 32'(k), 32'h0, 32'h0);
      checks++; if (bus.valM !== 32'(k * 'h11)) begin fails++; $display("FAIL fill_readback k=%0d: got %h want %h", k, bus.valM, k * 'h11); end
    end
  endtask

  task automatic test_load();
    drive(4'h5, 32'd3, 32'h30, 32'h0);
    checks++; if (bus.mem_addr !== 32'd3) begin fails++; $display("FAIL load_addr: got %h want 3", bus.mem_addr); end
    checks++; if (bus.valM !== 32'h33) begin fails++; $display("FAIL load_valM: got %h want 33", bus.valM); end
    checks++; if (bus.mem_write !== 1'b0) begin fails++; $display("FAIL load_nowrite: got %b want 0", bus.mem_write); end
    next_cycle();
    checks++; if (bus.valM !== 32'h33) begin fails++; $display("FAIL load_unchanged: got %h want 33", bus.valM); end
  endtask

  task automatic test_push_pop();
    drive(4'hA, 32'd8, 32'h30, 32'h0);
    checks++; if (bus.mem_addr !== 32'd8 || bus.mem_wdata !== 32'h30) begin
      fails++; $display("FAIL push_sel: addr %h data %h want 8 30", bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    drive(4'hB, 32'h40, 32'd8, 32'h0);
    checks++; if (bus.mem_addr !== 32'd8) begin fails++; $display("FAIL pop_addr: got %h want 8", bus.mem_addr); end
    checks++; if (bus.valM !== 32'h30) begin fails++; $display("FAIL pop_valM: got %h want 30", bus.valM); end
  endtask

  task automatic test_call_ret();
    drive(4'h8, 32'd9, 32'h55, 32'h99);
    checks++; if (bus.mem_wdata !== 32'h99 || bus.mem_write !== 1'b1) begin
      fails++; $display("FAIL call_sel: data %h w %b want 99 1", bus.mem_wdata, bus.mem_write);
    end
    next_cycle();
    drive(4'h9, 32'h77, 32'd9, 32'h0);
    checks++; if (bus.mem_addr !== 32'd9) begin fails++; $display("FAIL ret_addr: got %h want 9", bus.mem_addr); end
    checks++; if (bus.valM !== 32'h99) begin fails++; $display("FAIL ret_valM: got %h want 99", bus.valM); end
  endtask

  task automatic test_range();
    drive(4'h5, 32'(DEPTH), 32'h0, 32'h0);
    checks++; if (bus.dmem_error !== 1'b1 || bus.valM !== 32'h0) begin
      fails++; $display("FAIL rd_oor: err %b valM %h want 1 0", bus.dmem_error, bus.valM);
    end
    drive(4'h5, 32'hFFFF_FFFF, 32'h0, 32'h0);
    checks++; if (bus.dmem_error !== 1'b1) begin fails++; $display("FAIL rd_oor_max: got %b want 1", bus.dmem_error); end
    drive(4'h4, 32'(DEPTH), 32'hDEAD, 32'h0);
    checks++; if (bus.dmem_error !== 1'b1) begin fails++; $display("FAIL wr_oor_err: got %b want 1", bus.dmem_error); end
    next_cycle();
    drive(4'h4, 32'h103, 32'hBEEF, 32'h0);
    next_cycle();
    drive(4'h5, 32'd0, 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'h0) begin fails++; $display("FAIL wr_oor_alias0: got %h want 0", bus.valM); end
    drive(4'h5, 32'd3, 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'h33) begin fails++; $display("FAIL wr_oor_alias3: got %h want 33", bus.valM); end
    drive(4'h0, 32'd5, 32'd5, 32'd5);
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.dmem_error !== 1'b0 || bus.valM !== 32'h0 || bus.mem_addr !== 32'h0) begin
      fails++; $display("FAIL noop: r %b w %b err %b valM %h addr %h want 0 0 0 0 0", bus.mem_read, bus.mem_write, bus.dmem_error, bus.valM, bus.mem_addr);
    end
    drive(4'h5, 32'(DEPTH - 1), 32'h0, 32'h0);
    checks++; if (bus.dmem_error !== 1'b0 || bus.valM !== 32'h0) begin
      fails++; $display("FAIL rd_last: err %b valM %h want 0 0", bus.dmem_error, bus.valM);
    end
    drive(4'h4, 32'(DEPTH - 1), 32'hABCD, 32'h0);
    next_cycle();
    drive(4'h5, 32'(DEPTH - 1), 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'hABCD) begin fails++; $display("FAIL wr_last: got %h want abcd", bus.valM); end
  endtask

  task automatic test_reset_mid();
    drive(4'h5, 32'd3, 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'h33) begin fails++; $display("FAIL pre_reset: got %h want 33", bus.valM); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.valM !== 32'h0) begin fails++; $display("FAIL reset_clear: got %h want 0", bus.valM); end
    drive(4'h4, 32'd5, 32'h77, 32'h0);
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h5, 32'd5, 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'h0) begin fails++; $display("FAIL reset_blocks_write: got %h want 0", bus.valM); end
    drive(4'h4, 32'd6, 32'h66, 32'h0);
    next_cycle();
    drive(4'h5, 32'd6, 32'h0, 32'h0);
    checks++; if (bus.valM !== 32'h66) begin fails++; $display("FAIL first_write_after_reset: got %h want 66", bus.valM); end
  endtask

  initial begin
    test_reset();
    test_write_fill();
    test_load();
    test_push_pop();
    test_call_ret();
    test_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
